// File: rtl/p_mat_pkg.sv
// Shared definitions for the projection-matrix path: lane geometry, packer FSM states
// and lane-slice helpers used by both the band packer and the projection stage.
package p_mat_pkg;

  localparam int LANES      = 4;
  localparam int LANE_CNT_W = $clog2(LANES);

  typedef enum logic [1:0] {
    CLR,
    COLLECT,
    DRAIN,
    NORM
  } state_e;

  function automatic int words_for(input int bands);
    return (bands + LANES - 1) / LANES;
  endfunction

  function automatic int word_width(input int tw);
    return LANES * tw;
  endfunction

  function automatic int lane_lsb(input int lane, input int tw);
    return lane * tw;
  endfunction

endpackage

// File: rtl/lane_stager.sv
// Four-lane insert register: collects band samples lane by lane and presents the
// completed word (current sample already inserted) together with a done strobe.
module lane_stager
  import p_mat_pkg::*;
#(
  parameter int T_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_i,
  input  logic                             last_i,
  input  logic [T_WIDTH-1:0]               band_i,
  output logic [LANE_CNT_W-1:0]            lane_o,
  output logic [word_width(T_WIDTH)-1:0]   word_o,
  output logic                             done_o
);

  localparam int WW = word_width(T_WIDTH);

  logic [WW-1:0]         lanes_q, lanes_d;
  logic [LANE_CNT_W-1:0] lane_q, lane_d;

  always_comb begin
    lanes_d = lanes_q;
    lanes_d[lane_lsb(int'(lane_q), T_WIDTH) +: T_WIDTH] = band_i;
    done_o = push_i && ((lane_q == LANE_CNT_W'(LANES - 1)) || last_i);
    lane_d = lane_q;
    if (push_i) begin
      lane_d = done_o ? '0 : lane_q + 1'b1;
    end
  end

  assign word_o = lanes_d;
  assign lane_o = lane_q;

  // Clearing on completion leaves the upper lanes of a short final word at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (push_i) begin
      lanes_q <= done_o ? '0 : lanes_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/band_packer.sv
// Packs spectral bands four per word for the projection stage, sequences accumulator
// clears around each pixel and tracks the pixel index within the frame.
module band_packer
  import p_mat_pkg::*;
#(
  parameter int SPECTRAL_BANDS = 103,
  parameter int IN_I_WIDTH     = 16,
  parameter int IN_F_WIDTH     = 16,
  parameter int T_WIDTH        = 16,
  parameter int NUM_PIXELS     = 207400
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic signed [T_WIDTH-1:0]             s_band,
  output logic                                  out_valid,
  output logic [4*(IN_I_WIDTH+IN_F_WIDTH)-1:0]  out_pixel,
  output logic [$clog2(SPECTRAL_BANDS/2)-1:0]   out_col,
  output logic                                  mac_rst,
  output logic                                  norm_valid,
  output logic [$clog2(NUM_PIXELS)-1:0]         pixel_idx,
  output logic                                  frame_done
);

  localparam int OUT_W     = 4 * (IN_I_WIDTH + IN_F_WIDTH);
  localparam int WORD_W    = word_width(T_WIDTH);
  localparam int COL_W     = $clog2(SPECTRAL_BANDS / 2);
  localparam int PIX_W     = $clog2(NUM_PIXELS);
  localparam int WORDS     = words_for(SPECTRAL_BANDS);
  localparam int LAST_LANE = (SPECTRAL_BANDS - 1) % LANES;

  state_e                state_q;
  logic                  s_ready_q, mac_rst_q, norm_valid_q, frame_done_q, drain_q;
  logic [COL_W-1:0]      word_q;
  logic [PIX_W-1:0]      pixel_idx_q;
  logic [LANE_CNT_W-1:0] lane;
  logic [WORD_W-1:0]     word;
  logic                  hs, done, last_band;

  logic                  vld_p0_q, out_valid_q;
  logic [WORD_W-1:0]     word_p0_q;
  logic [COL_W-1:0]      out_col_q;
  logic [OUT_W-1:0]      out_pixel_q;

  assign hs        = s_valid && s_ready_q;
  assign last_band = (word_q == COL_W'(WORDS - 1)) && (lane == LANE_CNT_W'(LAST_LANE));

  lane_stager #(.T_WIDTH(T_WIDTH)) u_stager (
    .clk    (clk),
    .rst    (rst),
    .push_i (hs),
    .last_i (last_band),
    .band_i (s_band),
    .lane_o (lane),
    .word_o (word),
    .done_o (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLR;
      s_ready_q    <= 1'b0;
      mac_rst_q    <= 1'b0;
      norm_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      drain_q      <= 1'b0;
      word_q       <= '0;
      pixel_idx_q  <= '0;
    end else begin
      unique case (state_q)
        CLR: begin
          if (!mac_rst_q) begin
            mac_rst_q <= 1'b1;
          end else begin
            mac_rst_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= COLLECT;
          end
        end
        COLLECT: begin
          if (hs && last_band) begin
            word_q    <= '0;
            s_ready_q <= 1'b0;
            drain_q   <= 1'b0;
            state_q   <= DRAIN;
          end else if (done) begin
            word_q <= word_q + 1'b1;
          end
        end
        // Two drain cycles let the final word leave the address/data pipeline first.
        DRAIN: begin
          if (drain_q) begin
            norm_valid_q <= 1'b1;
            mac_rst_q    <= 1'b1;
            frame_done_q <= (pixel_idx_q == PIX_W'(NUM_PIXELS - 1));
            state_q      <= NORM;
          end else begin
            drain_q <= 1'b1;
          end
        end
        NORM: begin
          norm_valid_q <= 1'b0;
          mac_rst_q    <= 1'b0;
          frame_done_q <= 1'b0;
          s_ready_q    <= 1'b1;
          pixel_idx_q  <= (pixel_idx_q == PIX_W'(NUM_PIXELS - 1)) ? '0 : pixel_idx_q + 1'b1;
          state_q      <= COLLECT;
        end
        default: state_q <= CLR;
      endcase
    end
  end

  // p0: column address leads the data by one cycle to match the row memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q    <= 1'b0;
      word_p0_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      vld_p0_q <= done;
      if (done) begin
        word_p0_q <= word;
        out_col_q <= word_q;
      end
      out_valid_q <= vld_p0_q;
      if (vld_p0_q) begin
        out_pixel_q <= OUT_W'(word_p0_q);
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_col    = out_col_q;
  assign mac_rst    = mac_rst_q;
  assign norm_valid = norm_valid_q;
  assign pixel_idx  = pixel_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_band_packer.sv
// Directed-plus-random bench for band_packer: a cycle-indexed expectation table is filled
// from the band-to-lane packing rules and compared against the DUT every cycle.
module tb_band_packer;

  localparam int SB = 103;
  localparam int NP = 3;
  localparam int NC = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  s_band;
  logic         out_valid;
  logic [127:0] out_pixel;
  logic [5:0]   out_col;
  logic         mac_rst;
  logic         norm_valid;
  logic [1:0]   pixel_idx;
  logic         frame_done;

  band_packer #(.SPECTRAL_BANDS(SB), .NUM_PIXELS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_band     (s_band),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_col    (out_col),
    .mac_rst    (mac_rst),
    .norm_valid (norm_valid),
    .pixel_idx  (pixel_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b = 0;
  int p = 0;
  int blocked_until = 0;
  bit chk_en = 1'b0;

  bit          exp_ov [NC];
  logic [63:0] exp_word [NC];
  bit          exp_cv [NC];
  int          exp_col [NC];
  bit          exp_nv [NC];
  bit          exp_mr [NC];
  bit          exp_fd [NC];
  int          exp_pidx [NC];
  logic [15:0] pix [SB];
  bit          pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  // Reference: band b of a pixel sits in lane b%4 of word b/4; word appears 2 cycles later.
  task automatic accept(input logic [15:0] v);
    int c;
    int w;
    logic [63:0] wd;
    c = cyc - 1;
    pix[b] = v;
    if ((b % 4 == 3) || (b == SB - 1)) begin
      w  = b / 4;
      wd = '0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k <= b) wd[k*16 +: 16] = pix[w*4 + k];
      end
      if (c + 3 < NC) begin
        exp_ov[c+2] = 1'b1;  exp_word[c+2] = wd;
        exp_cv[c+1] = 1'b1;  exp_col[c+1]  = w;
        exp_cv[c+2] = 1'b1;  exp_col[c+2]  = w;
      end
    end
    if (b == SB - 1) begin
      blocked_until = c + 3;
      if (c + 3 < NC) begin
        exp_nv[c+3] = 1'b1;  exp_mr[c+3] = 1'b1;
        exp_pidx[c+3] = p;   exp_fd[c+3] = (p == NP - 1);
      end
      p = (p + 1) % NP;
      b = 0;
    end else begin
      b++;
    end
  endtask

  task automatic check_cycle();
    chk("out_valid",  128'(out_valid),  128'(exp_ov[cyc]));
    chk("s_ready",    128'(s_ready),    128'(cyc > blocked_until));
    chk("mac_rst",    128'(mac_rst),    128'(exp_mr[cyc]));
    chk("norm_valid", 128'(norm_valid), 128'(exp_nv[cyc]));
    chk("frame_done", 128'(frame_done), 128'(exp_fd[cyc]));
    if (exp_ov[cyc]) chk("out_pixel", out_pixel, {64'b0, exp_word[cyc]});
    if (exp_cv[cyc]) chk("out_col", 128'(out_col), 128'(exp_col[cyc]));
    if (exp_nv[cyc]) chk("pixel_idx", 128'(pixel_idx), 128'(exp_pidx[cyc]));
  endtask

  task automatic tick(output bit hs);
    logic [15:0] v;
    hs = (s_valid === 1'b1) && (s_ready === 1'b1) && (rst === 1'b0);
    v  = s_band;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) accept(v);
    if (chk_en && cyc < NC) check_cycle();
  endtask

  task automatic idle(input int n);
    bit hs;
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(hs);
  endtask

  task automatic do_reset();
    bit hs;
    chk_en  = 1'b0;
    rst     = 1'b1;
    s_valid = 1'b0;
    tick(hs);
    tick(hs);
    for (int i = 0; i < NC; i++) begin
      exp_ov[i] = 1'b0; exp_cv[i] = 1'b0; exp_nv[i] = 1'b0;
      exp_mr[i] = 1'b0; exp_fd[i] = 1'b0;
    end
    rst = 1'b0;
    b = 0;
    p = 0;
    blocked_until = cyc + 1;
    exp_mr[cyc+1] = 1'b1;
    chk_en = 1'b1;
    chk("rst_out_valid",  128'(out_valid),  128'(0));
    chk("rst_s_ready",    128'(s_ready),    128'(0));
    chk("rst_mac_rst",    128'(mac_rst),    128'(0));
    chk("rst_norm_valid", 128'(norm_valid), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_out_pixel",  out_pixel,        128'(0));
    chk("rst_out_col",    128'(out_col),    128'(0));
    chk("rst_pixel_idx",  128'(pixel_idx),  128'(0));
  endtask

  // mode 0: back-to-back, 1: valid pattern 1-0-1-1-0, 2: random gaps
  task automatic send_pixel(input int n, input int mode, input bit seq);
    logic [15:0] vals [SB];
    int sent = 0;
    int guard = 0;
    int ph = 0;
    bit hs;
    for (int i = 0; i < SB; i++) vals[i] = seq ? 16'(i + 1) : 16'($urandom);
    while (sent < n && guard < 2000) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = pat[ph % 5];
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_band = vals[sent];
      tick(hs);
      ph++;
      guard++;
      if (hs) sent++;
    end
    s_valid = 1'b0;
    chk("band_budget", 128'(sent), 128'(n));
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_band  = '0;
    do_reset();
    send_pixel(SB, 0, 1'b1);
    send_pixel(SB, 0, 1'b1);
    send_pixel(SB, 1, 1'b1);
    send_pixel(SB, 2, 1'b0);
    send_pixel(50, 0, 1'b1);
    idle(1);
    do_reset();
    send_pixel(SB, 2, 1'b0);
    send_pixel(SB, 1, 1'b0);
    idle(8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
